// File: rtl/mem_access_if.sv
// Bus bundle between the control unit / memory and mem_access_unit.
// The slave modport is the unit's view; the master modport is the environment's view.
interface mem_access_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        align_err;

  modport slave (
    input  req, we, size, addr, wdata, mem_rdata,
    output mem_addr, mem_wdata, mem_we, busy, done, rdata, align_err
  );

  modport master (
    output req, we, size, addr, wdata, mem_rdata,
    input  mem_addr, mem_wdata, mem_we, busy, done, rdata, align_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store sequencer for a word-organised synchronous memory; sub-word stores use read-modify-write.
// Optional misalignment trap enabled by defining MEM_ALIGN_CHECK_EN.
module mem_access_unit #(
  parameter int MEM_LAT = 2
) (
  input  logic clk,
  input  logic reset,
  mem_access_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] FIN  = 2'd3;

  logic [1:0]  state_reg;
  logic [2:0]  cnt_reg;
  logic        we_reg;
  logic [1:0]  size_reg;
  logic [1:0]  off_reg;
  logic [15:0] wdata_reg;
  logic [31:0] mem_addr_reg;
  logic [31:0] mem_wdata_reg;
  logic [31:0] rdata_reg;
  logic [31:0] ext_word;
  logic [31:0] merged_word;
  logic        req_is_word;
  logic        misalign;

  assign req_is_word = (bus.size == 2'b00) || (bus.size == 2'b11);

`ifdef MEM_ALIGN_CHECK_EN
  logic err_reg;
  assign misalign = ((bus.size == 2'b01) && bus.addr[0]) ||
                    (req_is_word && (bus.addr[1:0] != 2'b00));
  assign bus.align_err = (state_reg == FIN) && err_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      err_reg <= 1'b0;
    else if (state_reg == IDLE && bus.req)
      err_reg <= misalign;
  end
`else
  assign misalign      = 1'b0;
  assign bus.align_err = 1'b0;
`endif

  // Lane extraction for loads and lane replacement for sub-word stores.
  always_comb begin
    ext_word    = bus.mem_rdata;
    merged_word = bus.mem_rdata;
    case (size_reg)
      2'b01: begin
        ext_word = {16'h0000, bus.mem_rdata[{off_reg[1], 4'b0000} +: 16]};
        merged_word[{off_reg[1], 4'b0000} +: 16] = wdata_reg;
      end
      2'b10: begin
        ext_word = {24'h000000, bus.mem_rdata[{off_reg, 3'b000} +: 8]};
        merged_word[{off_reg, 3'b000} +: 8] = wdata_reg[7:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= 3'd0;
      we_reg        <= 1'b0;
      size_reg      <= 2'b00;
      off_reg       <= 2'b00;
      wdata_reg     <= 16'h0000;
      mem_addr_reg  <= 32'h0;
      mem_wdata_reg <= 32'h0;
      rdata_reg     <= 32'h0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.req) begin
            we_reg    <= bus.we;
            size_reg  <= bus.size;
            // Half accesses only honour addr[1]; the low bit is dropped here.
            off_reg   <= (bus.size == 2'b01) ? {bus.addr[1], 1'b0} : bus.addr[1:0];
            wdata_reg <= bus.wdata[15:0];
            cnt_reg   <= 3'(MEM_LAT - 1);
            if (misalign) begin
              state_reg <= FIN;
            end else begin
              mem_addr_reg <= {bus.addr[31:2], 2'b00};
              if (bus.we && req_is_word) begin
                mem_wdata_reg <= bus.wdata;
                state_reg     <= WR;
              end else begin
                state_reg <= RD;
              end
            end
          end
        end
        RD: begin
          if (cnt_reg == 3'd0) begin
            if (we_reg) begin
              mem_wdata_reg <= merged_word;
              state_reg     <= WR;
            end else begin
              rdata_reg <= ext_word;
              state_reg <= FIN;
            end
          end else begin
            cnt_reg <= cnt_reg - 3'd1;
          end
        end
        WR:      state_reg <= FIN;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign bus.rdata     = rdata_reg;
  // Decoded from state so an asynchronous reset removes the write strobe at once.
  assign bus.mem_we    = (state_reg == WR);
  assign bus.busy      = (state_reg != IDLE);
  assign bus.done      = (state_reg == FIN);

endmodule
